// File: rtl/regseq_pkg.sv
// Shared definitions for the register-file sequencer: opcodes, FSM states and
// instruction field positions.
package regseq_pkg;

    localparam int unsigned INSTR_W  = 16;

    localparam int unsigned OPC_MSB  = 15;
    localparam int unsigned OPC_LSB  = 12;
    localparam int unsigned DEST_MSB = 11;
    localparam int unsigned DEST_LSB = 8;
    localparam int unsigned SRC1_MSB = 7;
    localparam int unsigned SRC1_LSB = 4;
    localparam int unsigned SRC2_MSB = 3;
    localparam int unsigned SRC2_LSB = 0;
    localparam int unsigned IMM_MSB  = 7;
    localparam int unsigned IMM_LSB  = 0;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_LOAD    = 4'h0;
    localparam opcode_t OP_ADD     = 4'h1;
    localparam opcode_t OP_ADDI    = 4'h2;
    localparam opcode_t OP_SUB     = 4'h3;
    localparam opcode_t OP_SUBI    = 4'h4;
    localparam opcode_t OP_AND     = 4'h5;
    localparam opcode_t OP_OR      = 4'h6;
    localparam opcode_t OP_XOR     = 4'h7;
    localparam opcode_t OP_NOT     = 4'h8;
    localparam opcode_t OP_SHL     = 4'h9;
    localparam opcode_t OP_SHR     = 4'hA;
    localparam opcode_t OP_MUL     = 4'hB;
    localparam opcode_t OP_DISPLAY = 4'hC;
    localparam opcode_t OP_CLEAR   = 4'hD;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_CLEAR
    } state_e;

endpackage

// File: rtl/regseq_alu.sv
// Combinational ALU for the sequencer. writes_o flags opcodes that write back;
// carry_o is carry-out for ADD/ADDI and borrow for SUB/SUBI.
module regseq_alu
    import regseq_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  opcode_t           op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [7:0]        imm_i,
    output logic [DATA_W-1:0] y_o,
    output logic              carry_o,
    output logic              writes_o
);

    logic [DATA_W-1:0] imm4;
    logic [DATA_W-1:0] imm8;

    assign imm4 = DATA_W'(imm_i[3:0]);
    assign imm8 = DATA_W'(imm_i);

    always_comb begin
        y_o      = '0;
        carry_o  = 1'b0;
        writes_o = 1'b1;
        case (op_i)
            OP_LOAD:    y_o = imm8;
            OP_ADD:     {carry_o, y_o} = {1'b0, a_i} + {1'b0, b_i};
            OP_ADDI:    {carry_o, y_o} = {1'b0, a_i} + {1'b0, imm4};
            // Top bit of the widened difference is the borrow.
            OP_SUB:     {carry_o, y_o} = {1'b0, a_i} - {1'b0, b_i};
            OP_SUBI:    {carry_o, y_o} = {1'b0, a_i} - {1'b0, imm4};
            OP_AND:     y_o = a_i & b_i;
            OP_OR:      y_o = a_i | b_i;
            OP_XOR:     y_o = a_i ^ b_i;
            OP_NOT:     y_o = ~a_i;
            OP_SHL:     y_o = a_i << imm_i[3:0];
            OP_SHR:     y_o = a_i >> imm_i[3:0];
            OP_MUL:     y_o = a_i * b_i;
            OP_DISPLAY: begin
                y_o      = a_i;
                writes_o = 1'b0;
            end
            default:    writes_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Multi-cycle controller driving a register file: IDLE -> READ -> WRITE, or a
// NUM_REGS-cycle CLEAR sweep. Optional status flags under REGSEQ_FLAGS_EN.
module regfile_sequencer
    import regseq_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    output logic [ADDR_W-1:0]  rf_src1,
    output logic [ADDR_W-1:0]  rf_src2,
    input  logic [DATA_W-1:0]  rf_rdata1,
    input  logic [DATA_W-1:0]  rf_rdata2,
    output logic [ADDR_W-1:0]  rf_dest,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic               rf_we,
    output logic               busy,
    output logic               done,
`ifdef REGSEQ_FLAGS_EN
    output logic               flag_z,
    output logic               flag_n,
    output logic               flag_c,
`endif
    output logic [DATA_W-1:0]  result
);

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(NUM_REGS - 1);

    state_e               state_q;
    logic [INSTR_W-1:0]   instr_q;
    logic [ADDR_W-1:0]    rf_src1_q, rf_src2_q, rf_dest_q, cnt_q;
    logic [DATA_W-1:0]    rf_wdata_q, result_q;
    logic                 rf_we_q, done_q;

    opcode_t              op;
    logic [DATA_W-1:0]    alu_y;
    logic                 alu_carry, alu_writes;

    assign op = instr_q[OPC_MSB:OPC_LSB];

    regseq_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i     (op),
        .a_i      (rf_rdata1),
        .b_i      (rf_rdata2),
        .imm_i    (instr_q[IMM_MSB:IMM_LSB]),
        .y_o      (alu_y),
        .carry_o  (alu_carry),
        .writes_o (alu_writes)
    );

`ifdef REGSEQ_FLAGS_EN
    logic carry_q, flag_z_q, flag_n_q, flag_c_q;
`else
    logic unused_carry;
    assign unused_carry = alu_carry;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            instr_q    <= '0;
            rf_src1_q  <= '0;
            rf_src2_q  <= '0;
            rf_dest_q  <= '0;
            rf_wdata_q <= '0;
            rf_we_q    <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            cnt_q      <= '0;
`ifdef REGSEQ_FLAGS_EN
            carry_q    <= 1'b0;
            flag_z_q   <= 1'b0;
            flag_n_q   <= 1'b0;
            flag_c_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (instr_valid) begin
                        instr_q   <= instr;
                        rf_src1_q <= ADDR_W'(instr[SRC1_MSB:SRC1_LSB]);
                        rf_src2_q <= ADDR_W'(instr[SRC2_MSB:SRC2_LSB]);
                        state_q   <= S_READ;
                    end
                end
                S_READ: begin
                    if (op == OP_CLEAR) begin
                        state_q    <= S_CLEAR;
                        cnt_q      <= '0;
                        rf_dest_q  <= '0;
                        rf_wdata_q <= '0;
                        rf_we_q    <= 1'b1;
                        done_q     <= 1'b0;
                    end else begin
                        state_q    <= S_WRITE;
                        rf_dest_q  <= ADDR_W'(instr_q[DEST_MSB:DEST_LSB]);
                        rf_wdata_q <= alu_y;
                        rf_we_q    <= alu_writes;
                        done_q     <= 1'b1;
`ifdef REGSEQ_FLAGS_EN
                        carry_q    <= alu_carry;
`endif
                    end
                end
                S_WRITE: begin
                    state_q <= S_IDLE;
                    rf_we_q <= 1'b0;
                    done_q  <= 1'b0;
                    if (alu_writes || op == OP_DISPLAY) begin
                        result_q <= rf_wdata_q;
                    end
`ifdef REGSEQ_FLAGS_EN
                    if (alu_writes) begin
                        flag_z_q <= (rf_wdata_q == '0);
                        flag_n_q <= rf_wdata_q[DATA_W-1];
                        flag_c_q <= carry_q;
                    end
`endif
                end
                S_CLEAR: begin
                    // Leaving through IDLE is the only way the counter wraps.
                    if (cnt_q == CLR_LAST) begin
                        state_q  <= S_IDLE;
                        rf_we_q  <= 1'b0;
                        done_q   <= 1'b0;
                        result_q <= '0;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q     <= cnt_q + 1'b1;
                        rf_dest_q <= cnt_q + 1'b1;
                        done_q    <= ((cnt_q + 1'b1) == CLR_LAST);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign rf_src1     = rf_src1_q;
    assign rf_src2     = rf_src2_q;
    assign rf_dest     = rf_dest_q;
    assign rf_wdata    = rf_wdata_q;
    assign rf_we       = rf_we_q;
    assign done        = done_q;
    assign result      = result_q;
`ifdef REGSEQ_FLAGS_EN
    assign flag_z      = flag_z_q;
    assign flag_n      = flag_n_q;
    assign flag_c      = flag_c_q;
`endif

endmodule
